ps2_kbd_rx: RTL and testbench
=============================

// Module: ps2_kbd_rx
// PURPOSE
//  PS/2 keyboard receiver: the input direction of our display-out system. Deserialises
//  device-to-host PS/2 frames into scan-code bytes and buffers them in a small FIFO.
//  The MIPS reads the FIFO through a memory-mapped port. Sits beside vga640x480/charmem
//  in the top level and runs on CLOCK_25.
// PARAMETERS
//  FIFO_DEPTH   8       scan-code FIFO entries, power of 2, >=2
//  FILTER_LEN   4       consecutive equal samples needed to accept a ps2_clk level change
//  TIMEOUT_CYC  50000   idle cycles (2 ms @ 25 MHz) mid-frame before the frame is abandoned
// PORTS
//  clk          in   1  system clock (CLOCK_25)
//  clr_n        in   1  asynchronous reset, active low
//  ps2_clk      in   1  PS/2 clock from the device, asynchronous
//  ps2_data     in   1  PS/2 data from the device, asynchronous
//  rd_en        in   1  pop strobe from the CPU memory decode (1 cycle per byte)
//  err_clr      in   1  clears the sticky error flags
//  rd_data      out  8  FIFO head byte (first-word fall-through); 8'h00 when empty
//  rd_valid     out  1  FIFO non-empty
//  overflow     out  1  sticky: a good frame was dropped because the FIFO was full
//  frame_err    out  1  sticky: parity, stop-bit or timeout error
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM in IDLE, timeout counter 0, sync flops 1.
//  Input path: ps2_clk and ps2_data each go through 2-FF synchronisers. ps2_clk then goes
//   through the FILTER_LEN glitch filter. A bit is sampled on the 1->0 edge of the filtered clock.
//  Frame: start(0), D0..D7 LSB first, odd parity, stop(1). 11 falling edges per frame.
//  FSM states IDLE, DATA, PARITY, STOP:
//   IDLE   -> DATA on an edge with data==0. An edge with data==1 is ignored.
//   DATA   -> shift right into sr[7:0], bit counter 0..7, -> PARITY after the 8th bit.
//   PARITY -> latch the parity bit, -> STOP.
//   STOP   -> the frame is good when ^{sr,parity}==1 and stop==1. Always -> IDLE.
//  On a good frame, push sr in the cycle after the stop edge. rd_valid rises on the next cycle.
//  On a bad frame, nothing is pushed and frame_err is set.
//  Timeout: in any state other than IDLE, the counter increments each cycle with no edge
//   and clears on an edge. When it reaches TIMEOUT_CYC-1: -> IDLE, set frame_err, no push.
//  FIFO: a push is accepted when !full, or when full with rd_en in the same cycle
//   (pop and push together; the count stays at DEPTH).
//   A push while full with no pop is dropped, sets overflow, and leaves the FIFO unchanged.
//   rd_en while empty is ignored; count never underflows.
//   Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. The count is one bit wider.
//  Sticky flags: err_clr clears them. If err_clr and a new error occur in the same cycle,
//   the flag ends up set (set wins).
//  Asserting clr_n low mid-frame discards the partial frame and empties the FIFO at once.
// CONFIGURATION
//  PS2_BREAK_FILTER_EN defined:
//   - A good frame of 8'hF0 is not pushed and arms a "skip" flag.
//   - The next good frame is also dropped, then skip clears, so key releases never reach
//     the CPU.
//   - A frame error or timeout clears skip.
//   - 8'hE0 prefixes pass through unchanged.
//  Not defined: every good byte is pushed raw, including F0. The skip flag is not built.
// STRUCTURE
//  ps2_pkg: typedef enum logic [1:0] {IDLE,DATA,PARITY,STOP} ps2_state_t;
//   localparam PS2_BREAK = 8'hF0, PS2_EXT = 8'hE0.
//  Sub-module ps2_fifo (FIFO_DEPTH x 8, first-word fall-through, push/pop/full/empty).
//   Instantiated once. The FSM, synchronisers, filter and timeout live in ps2_kbd_rx.
// TESTING
//  1 Send frame 8'h1C (odd parity bit=0, stop=1) at 12.5 kHz -> rd_valid=1, rd_data=8'h1C;
//    rd_en pulse -> rd_valid=0, rd_data=8'h00.
//  2 Send 8'h1C with the parity bit flipped -> no push, frame_err=1;
//    err_clr pulse -> frame_err=0.
//  3 Send 9 good bytes 8'h01..8'h09 with no reads -> 8 stored, overflow=1;
//    reads return 01..08 in order.
//  4 FIFO full, 9th frame's push coincides with rd_en -> 01 popped, 09 stored, overflow=0.
//  5 Send 3 bits of a frame, then hold ps2_clk high for 50000 cycles -> FSM IDLE,
//    frame_err=1; a following frame 8'h2A is received correctly.
//  6 Send F0,1C,1C: with PS2_BREAK_FILTER_EN only one 8'h1C is read;
//    without it, F0,1C,1C are read.
//    Also inject 2-cycle ps2_clk glitches -> no extra bits sampled.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 receiver state type and scan-code constants
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;
endpackage

// File: rtl/ps2_fifo.sv
// ps2_fifo: first-word fall-through scan-code FIFO; a push while full is dropped unless popped together
module ps2_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_drop
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_cnt;
  logic w_full, w_pop, w_push;
  assign w_full = r_cnt == (AW+1)'(DEPTH);
  assign o_valid = r_cnt != '0;
  assign w_pop = i_pop && o_valid;
  assign w_push = i_push && (!w_full || w_pop);
  assign o_drop = i_push && w_full && !w_pop;
  assign o_data = o_valid ? r_mem[r_rptr] : 8'h00;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= i_data;
endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver into a scan-code FIFO; PS2_BREAK_FILTER_EN drops F0 and the byte after it
module ps2_kbd_rx import ps2_pkg::*; #(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  input  logic       err_clr,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       overflow,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [1:0] r_clk_s, r_dat_s;
  logic r_fclk;
  logic [FW-1:0] r_fcnt;
  logic w_diff, w_flip, w_fall;
  ps2_state_t r_state, w_state;
  logic [2:0] r_bcnt, w_bcnt;
  logic [7:0] r_sr, w_sr;
  logic r_par, w_par;
  logic [TW-1:0] r_tcnt, w_tcnt;
  logic w_good, w_bad, w_tout, w_keep, w_drop;
  logic r_push;
  logic [7:0] r_pdata;
  assign w_diff = r_clk_s[1] != r_fclk;
  assign w_flip = w_diff && r_fcnt == FW'(FILTER_LEN - 1);
  assign w_fall = w_flip && r_fclk;
  always_comb begin
    w_state = r_state;
    w_bcnt = r_bcnt;
    w_sr = r_sr;
    w_par = r_par;
    w_good = 1'b0;
    w_bad = 1'b0;
    w_tout = r_state != IDLE && r_tcnt == TW'(TIMEOUT_CYC - 1);
    w_tcnt = (r_state == IDLE || w_fall || w_tout) ? '0 : r_tcnt + 1'b1;
    if (w_tout) begin
      w_state = IDLE;
      w_bad = 1'b1;
    end else if (w_fall)
      case (r_state)
        IDLE: if (!r_dat_s[1]) begin
          w_state = DATA;
          w_bcnt = '0;
        end
        DATA: begin
          w_sr = {r_dat_s[1], r_sr[7:1]};
          w_bcnt = r_bcnt + 1'b1;
          w_state = r_bcnt == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          w_par = r_dat_s[1];
          w_state = STOP;
        end
        default: begin
          w_state = IDLE;
          w_good = (^{r_sr, r_par}) && r_dat_s[1];
          w_bad = !w_good;
        end
      endcase
  end
`ifdef PS2_BREAK_FILTER_EN
  logic r_skip;
  assign w_keep = w_good && !r_skip && r_sr != PS2_BREAK;
  // a break arms the skip so the released key's code is swallowed too
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) r_skip <= 1'b0;
    else if (w_bad) r_skip <= 1'b0;
    else if (w_good) r_skip <= !r_skip && r_sr == PS2_BREAK;
`else
  assign w_keep = w_good;
`endif
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      r_clk_s <= '1;
      r_dat_s <= '1;
      r_fclk <= 1'b1;
      r_fcnt <= '0;
      r_state <= IDLE;
      r_bcnt <= '0;
      r_sr <= '0;
      r_par <= 1'b0;
      r_tcnt <= '0;
      r_push <= 1'b0;
      r_pdata <= '0;
      overflow <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      r_clk_s <= {r_clk_s[0], ps2_clk};
      r_dat_s <= {r_dat_s[0], ps2_data};
      r_fcnt <= (w_diff && !w_flip) ? r_fcnt + 1'b1 : '0;
      if (w_flip) r_fclk <= r_clk_s[1];
      r_state <= w_state;
      r_bcnt <= w_bcnt;
      r_sr <= w_sr;
      r_par <= w_par;
      r_tcnt <= w_tcnt;
      r_push <= w_keep;
      r_pdata <= r_sr;
      overflow <= w_drop | (overflow & ~err_clr);
      frame_err <= w_bad | (frame_err & ~err_clr);
    end
  ps2_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .clr_n(clr_n),
    .i_push(r_push),
    .i_data(r_pdata),
    .i_pop(rd_en),
    .o_data(rd_data),
    .o_valid(rd_valid),
    .o_drop(w_drop)
  );
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed and random PS/2 frames checked against a queue-based receiver model
module tb_ps2_kbd_rx;
  localparam int DEPTH = 8;
  localparam int TO = 600;
  localparam int H = 20;
  logic clk = 1'b0;
  logic clr_n = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic rd_en = 1'b0;
  logic err_clr = 1'b0;
  logic [7:0] rd_data;
  logic rd_valid, overflow, frame_err;
  int n_pass = 0;
  int n_tot = 0;
  int n_fail = 0;
  byte unsigned q[$];
  bit m_ovf = 0;
  bit m_err = 0;
`ifdef PS2_BREAK_FILTER_EN
  bit m_skip = 0;
`endif
  always #20 clk = ~clk;
  ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(4), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .clr_n(clr_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .err_clr(err_clr), .rd_data(rd_data), .rd_valid(rd_valid),
    .overflow(overflow), .frame_err(frame_err)
  );
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, ".valid"}, {7'd0, rd_valid}, {7'd0, q.size() != 0});
    check({tag, ".data"}, rd_data, q.size() != 0 ? q[0] : 8'h00);
    check({tag, ".ovf"}, {7'd0, overflow}, {7'd0, m_ovf});
    check({tag, ".err"}, {7'd0, frame_err}, {7'd0, m_err});
  endtask
  task automatic model_frame(input byte unsigned b, input bit good);
    if (!good) begin
      m_err = 1;
`ifdef PS2_BREAK_FILTER_EN
      m_skip = 0;
`endif
      return;
    end
`ifdef PS2_BREAK_FILTER_EN
    if (m_skip) begin
      m_skip = 0;
      return;
    end
    if (b == 8'hF0) begin
      m_skip = 1;
      return;
    end
`endif
    if (q.size() < DEPTH) q.push_back(b);
    else m_ovf = 1;
  endtask
  // act: 1 pulses rd_en, 2 pulses err_clr, in the cycle the stop bit's push lands
  task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0,
                            input int glitch = 0, input int nbits = 11, input int act = 0);
    logic [10:0] f;
    f = {~bad_stop, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (glitch > 0) begin
        tick(5);
        ps2_clk = 1'b0;
        tick(glitch);
        ps2_clk = 1'b1;
        tick(H - 5 - glitch);
      end else tick(H);
      ps2_clk = 1'b0;
      if (i == 10 && act != 0) begin
        tick(6);
        if (act == 1) rd_en = 1'b1;
        else err_clr = 1'b1;
        tick(1);
        rd_en = 1'b0;
        err_clr = 1'b0;
        tick(H - 7);
      end else tick(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(H);
    if (nbits == 11) begin
      if (act == 1 && q.size() != 0) void'(q.pop_front());
      if (act == 2) begin
        m_ovf = 0;
        m_err = 0;
      end
      model_frame(b, !bad_par && !bad_stop);
    end
  endtask
  task automatic read_one(input string tag);
    check({tag, ".rv"}, {7'd0, rd_valid}, {7'd0, q.size() != 0});
    check({tag, ".rd"}, rd_data, q.size() != 0 ? q[0] : 8'h00);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask
  task automatic clear_err();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    m_err = 0;
    m_ovf = 0;
  endtask
  task automatic drain(input string tag);
    while (q.size() != 0) read_one(tag);
    check({tag, ".empty"}, {7'd0, rd_valid}, 8'd0);
  endtask
  initial begin
    #5 clr_n = 1'b0;
    tick(3);
    check_all("reset");
    clr_n = 1'b1;
    tick(2);
    send_frame(8'h1C);
    check_all("t1");
    read_one("t1");
    check_all("t1.pop");
    send_frame(8'h1C, 1);
    check_all("t2.par");
    clear_err();
    check_all("t2.clr");
    send_frame(8'h55, 0, 1);
    check_all("t2.stop");
    clear_err();
    for (int i = 1; i <= 9; i++) send_frame(8'(i));
    check_all("t3");
    drain("t3");
    clear_err();
    for (int i = 1; i <= 8; i++) send_frame(8'(i));
    send_frame(8'h09, 0, 0, 0, 11, 1);
    check_all("t4");
    send_frame(8'h0B);
    check_all("t4.drop");
    send_frame(8'h0C, 0, 0, 0, 11, 2);
    check_all("setwins");
    drain("t4");
    clear_err();
    send_frame(8'h2A, 0, 0, 0, 3);
    tick(TO / 2);
    check("t5.early", {7'd0, frame_err}, 8'd0);
    tick(TO);
    m_err = 1;
    check_all("t5.tout");
    clear_err();
    send_frame(8'h2A);
    check_all("t5.after");
    read_one("t5");
    send_frame(8'h11);
    send_frame(8'h77, 0, 0, 0, 4);
    clr_n = 1'b0;
    tick(1);
    q.delete();
    m_err = 0;
    m_ovf = 0;
`ifdef PS2_BREAK_FILTER_EN
    m_skip = 0;
`endif
    check_all("rst.mid");
    clr_n = 1'b1;
    tick(2);
    send_frame(8'h33);
    check_all("rst.after");
    read_one("rst");
    send_frame(8'hF0, 0, 0, 2);
    send_frame(8'h1C, 0, 0, 3);
    send_frame(8'h1C, 0, 0, 2);
    send_frame(8'hE0, 0, 0, 1);
    check_all("t6");
    drain("t6");
    for (int i = 0; i < 14; i++) begin
      send_frame(8'($urandom), $urandom_range(0, 3) == 0, 1'b0, $urandom_range(0, 3));
      check_all("rnd");
      if ($urandom_range(0, 1) == 1) read_one("rnd");
    end
    drain("rnd");
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
